// File: rtl/mandel_param_loader.sv
// mandel_param_loader: watches the step/base parameter words, waits for them
// to settle, then loads start_i = base + i*step into each solver core over a
// valid/ready handshake while holding the solver array in restart.
module mandel_param_loader #(
    parameter int unsigned      WIDTH         = 27,
    parameter int unsigned      NUM_CORES     = 8,
    parameter int unsigned      IDX_W         = 3,
    parameter int unsigned      SETTLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_STEP    = 27'h7000000,
    parameter logic [WIDTH-1:0] RESET_BASE    = 27'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] step_in,
    input  logic [WIDTH-1:0] base_in,
    output logic             load_valid,
    input  logic             load_ready,
    output logic [IDX_W-1:0] core_sel,
    output logic [WIDTH-1:0] core_start,
    output logic             solver_restart,
    output logic             busy,
    output logic             load_done
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(NUM_CORES - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] step_sh_q, step_sh_d;
    logic [WIDTH-1:0] base_sh_q, base_sh_d;
    logic [WIDTH-1:0] step_l_q, step_l_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [IDX_W-1:0] core_sel_q, core_sel_d;
    logic [WIDTH-1:0] core_start_q, core_start_d;
    logic             load_valid_q, load_valid_d;
    logic             solver_restart_q, solver_restart_d;
    logic             busy_q, busy_d;
    logic             load_done_q, load_done_d;
    logic             chg_c;

    // One-cycle change detect against the previous cycle's parameter words
    assign chg_c = (step_in != step_sh_q) || (base_in != base_sh_q);

    // State register; reset lands in SETTLE so a startup load always runs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_SETTLE;
            step_sh_q        <= RESET_STEP;
            base_sh_q        <= RESET_BASE;
            step_l_q         <= '0;
            settle_cnt_q     <= '0;
            core_sel_q       <= '0;
            core_start_q     <= '0;
            load_valid_q     <= 1'b0;
            solver_restart_q <= 1'b0;
            busy_q           <= 1'b0;
            load_done_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            step_sh_q        <= step_sh_d;
            base_sh_q        <= base_sh_d;
            step_l_q         <= step_l_d;
            settle_cnt_q     <= settle_cnt_d;
            core_sel_q       <= core_sel_d;
            core_start_q     <= core_start_d;
            load_valid_q     <= load_valid_d;
            solver_restart_q <= solver_restart_d;
            busy_q           <= busy_d;
            load_done_q      <= load_done_d;
        end
    end

    // Next-state and registered-output logic; core_start doubles as the accumulator
    always_comb begin
        state_d          = state_q;
        step_sh_d        = step_in;
        base_sh_d        = base_in;
        step_l_d         = step_l_q;
        settle_cnt_d     = settle_cnt_q;
        core_sel_d       = core_sel_q;
        core_start_d     = core_start_q;
        load_valid_d     = load_valid_q;
        solver_restart_d = solver_restart_q;
        load_done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (chg_c) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (chg_c) begin
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == CNT_LAST) begin
                    step_l_d         = step_sh_q;
                    core_start_d     = base_sh_q;
                    core_sel_d       = '0;
                    load_valid_d     = 1'b1;
                    solver_restart_d = 1'b1;
                    state_d          = ST_LOAD;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (chg_c) begin
                    // Abort: keep the array in restart and re-settle from scratch
                    load_valid_d = 1'b0;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end else if (load_ready) begin
                    if (core_sel_q == SEL_LAST) begin
                        load_valid_d     = 1'b0;
                        load_done_d      = 1'b1;
                        solver_restart_d = 1'b0;
                        state_d          = ST_DONE;
                    end else begin
                        core_sel_d   = core_sel_q + IDX_W'(1);
                        core_start_d = core_start_q + step_l_q;
                    end
                end
            end
            ST_DONE: begin
                if (chg_c) begin
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign load_valid     = load_valid_q;
    assign core_sel       = core_sel_q;
    assign core_start     = core_start_q;
    assign solver_restart = solver_restart_q;
    assign busy           = busy_q;
    assign load_done      = load_done_q;

endmodule

// File: tb/tb_mandel_param_loader.sv
// Testbench for mandel_param_loader: directed scenarios with randomized
// parameter words and handshake timing, checked against start = base + i*step.
module tb_mandel_param_loader;

    localparam int unsigned W = 27;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] step_in;
    logic [W-1:0] base_in;
    logic         load_valid;
    logic         load_ready;
    logic [2:0]   core_sel;
    logic [W-1:0] core_start;
    logic         solver_restart;
    logic         busy;
    logic         load_done;

    int n_tests = 0;
    int n_fail  = 0;

    mandel_param_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .step_in        (step_in),
        .base_in        (base_in),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .core_sel       (core_sel),
        .core_start     (core_start),
        .solver_restart (solver_restart),
        .busy           (busy),
        .load_done      (load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference start coordinate: plain arithmetic modulo 2^27
    function automatic logic [W-1:0] start_of(input logic [W-1:0] b, input logic [W-1:0] s,
                                              input int i);
        logic [63:0] t;
        t = (64'(b) + 64'(i) * 64'(s)) % (64'd1 << W);
        return t[W-1:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   32'(load_valid),     32'd0);
        chk({tag, "_restart"}, 32'(solver_restart), 32'd0);
        chk({tag, "_busy"},    32'(busy),           32'd0);
        chk({tag, "_done"},    32'(load_done),      32'd0);
        chk({tag, "_sel"},     32'(core_sel),       32'd0);
        chk({tag, "_start"},   32'(core_start),     32'd0);
    endtask

    // Wait for the load to start, then drive/observe the handshake.
    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
    // abort_kind: 0 change step at transfer abort_at, 1 assert reset at core abort_at.
    task automatic do_seq(input logic [W-1:0] b, input logic [W-1:0] s, input int mode,
                          input int lat, input logic rst_wait, input int abort_at,
                          input int abort_kind, input logic [W-1:0] abort_step);
        int           c;
        int           n;
        int           rcnt;
        logic         pv;
        logic         pr;
        logic         r;
        logic [2:0]   psel;
        logic [W-1:0] pstart;
        c    = 0;
        n    = 0;
        rcnt = 0;
        pv   = 1'b0;
        pr   = 1'b0;
        while (c < 100 && load_valid !== 1'b1) begin
            @(negedge clk);
            c++;
            if (load_valid !== 1'b1) begin
                chk("settle_restart", 32'(solver_restart), 32'(rst_wait));
                chk("settle_busy",    32'(busy),           32'd1);
            end
        end
        chk("latency", 32'(c), 32'(lat));
        if (load_valid !== 1'b1) return;
        for (int cyc = 0; cyc < 300 && n < int'(N); cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (pv && !pr) begin
                chk("stall_sel",   32'(core_sel),   32'(psel));
                chk("stall_start", 32'(core_start), 32'(pstart));
            end
            chk("valid_hold",   32'(load_valid),     32'd1);
            chk("load_restart", 32'(solver_restart), 32'd1);
            chk("load_busy",    32'(busy),           32'd1);
            pv     = load_valid;
            psel   = core_sel;
            pstart = core_start;
            case (mode)
                0:       r = 1'b1;
                1:       r = ((rcnt % 3) == 0);
                default: r = 1'($urandom % 2);
            endcase
            rcnt++;
            load_ready = r;
            pr         = r;
            if (load_valid === 1'b1 && r) begin
                chk("xfer_sel",   32'(core_sel),   32'(n));
                chk("xfer_start", 32'(core_start), 32'(start_of(b, s, n)));
                if (n == abort_at) begin
                    if (abort_kind == 0) begin
                        step_in = abort_step;
                    end else begin
                        reset_n = 1'b0;
                        #1;
                        chk_all_zero("async_rst");
                    end
                    return;
                end
                n++;
            end
        end
        chk("xfer_count", 32'(n), 32'(N));
        @(negedge clk);
        chk("done_pulse",   32'(load_done),      32'd1);
        chk("done_valid",   32'(load_valid),     32'd0);
        chk("done_restart", 32'(solver_restart), 32'd0);
        chk("done_busy",    32'(busy),           32'd1);
        load_ready = 1'($urandom % 2);
        @(negedge clk);
        chk("idle_done",  32'(load_done),  32'd0);
        chk("idle_busy",  32'(busy),       32'd0);
        chk("idle_valid", 32'(load_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic [W-1:0] s2;

        reset_n    = 1'b0;
        step_in    = 27'h7000000;
        base_in    = 27'h0;
        load_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");

        // Startup load after reset release with reset-valued inputs
        reset_n = 1'b1;
        do_seq(27'h0, 27'h7000000, 0, 16, 1'b0, -1, 0, 27'h0);

        // From IDLE: base -0.5, small step
        base_in = 27'h7C00000;
        step_in = 27'h0002000;
        do_seq(27'h7C00000, 27'h0002000, 0, 17, 1'b0, -1, 0, 27'h0);

        // Backpressure with ready pattern 1,0,0
        b       = base_in + 27'($urandom_range(1, 1000000));
        s       = 27'($urandom);
        base_in = b;
        step_in = s;
        do_seq(b, s, 1, 17, 1'b0, -1, 0, 27'h0);

        // Step churns every 5 cycles for 40 cycles, then holds
        for (int k = 0; k < 8; k++) begin
            step_in = step_in + 27'($urandom_range(1, 5000));
            if (k < 7) begin
                repeat (5) begin
                    @(negedge clk);
                    chk("churn_valid", 32'(load_valid), 32'd0);
                end
            end
        end
        do_seq(base_in, step_in, 2, 17, 1'b0, -1, 0, 27'h0);

        // Step change coincident with the transfer for core 3
        b       = base_in + 27'($urandom_range(1, 1000000));
        s       = step_in;
        s2      = step_in + 27'($urandom_range(1, 5000));
        base_in = b;
        do_seq(b, s, 0, 17, 1'b0, 3, 0, s2);
        @(negedge clk);
        chk("abort_valid",   32'(load_valid),     32'd0);
        chk("abort_restart", 32'(solver_restart), 32'd1);
        chk("abort_busy",    32'(busy),           32'd1);
        do_seq(b, s2, 0, 16, 1'b1, -1, 0, 27'h0);

        // Reset asserted while core 5 is being offered
        b       = base_in + 27'($urandom_range(1, 1000000));
        base_in = b;
        do_seq(b, step_in, 1, 17, 1'b0, 5, 1, 27'h0);
        step_in = 27'h7000000;
        base_in = 27'h0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_valid", 32'(load_valid), 32'd0);
        end
        reset_n = 1'b1;
        do_seq(27'h0, 27'h7000000, 0, 16, 1'b0, -1, 0, 27'h0);

        // Fully random words with random ready
        b       = base_in + 27'($urandom_range(1, 1000000));
        s       = 27'($urandom);
        base_in = b;
        step_in = s;
        do_seq(b, s, 2, 17, 1'b0, -1, 0, 27'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
